// File: rtl/reflex_judge_if.sv
// Bundles the game-control inputs and the judge status outputs of reflex_judge.
// Latency: n/a (signal bundle only).
// Backpressure: none; every input is a level or a single-cycle pulse.
//
// Signals:
//   start        : one-cycle pulse that begins or restarts a game
//   target_valid : one-cycle pulse, target_id is valid
//   target_id    : index of the button that must be pressed
//   btn          : synchronized, debounced button levels (1 = pressed)
//   wrong_time   : accumulated wrong/miss count
//   score        : correct-hit count (saturating)
//   hit / wrong  : one-cycle judgement pulses
//   game_over    : high while the game is over
//   busy         : high while a game is in progress
interface reflex_judge_if;
  logic       start;
  logic       target_valid;
  logic [1:0] target_id;
  logic [3:0] btn;
  logic [2:0] wrong_time;
  logic [7:0] score;
  logic       hit;
  logic       wrong;
  logic       game_over;
  logic       busy;

  // master: the game controller / button front end driving the judge
  modport master (
    output start, target_valid, target_id, btn,
    input  wrong_time, score, hit, wrong, game_over, busy
  );

  // slave: the judge itself
  modport slave (
    input  start, target_valid, target_id, btn,
    output wrong_time, score, hit, wrong, game_over, busy
  );
endinterface

// File: rtl/reflex_judge.sv
// Judges button presses against a shown target inside a timed response window.
// Latency: hit/wrong pulse one cycle after the judged rise or timeout cycle.
// Backpressure: none; presses outside a window are ignored or counted as early.
//
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : reflex_judge_if.slave (start, target, buttons in; counters, pulses, status out)
module reflex_judge #(
  parameter int unsigned WINDOW_CYCLES = 50_000_000,
  parameter int unsigned MAX_WRONG     = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  reflex_judge_if.slave  bus
);

  localparam logic [31:0] LP_TIMER_LOAD = 32'(WINDOW_CYCLES - 1);
  localparam logic [2:0]  LP_MAX_WRONG  = 3'(MAX_WRONG);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_WINDOW  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_OVER    = 3'd4
  } state_t;

  state_t      r_state;
  logic [3:0]  r_btn_q;
  logic [31:0] r_timer;
  logic [1:0]  r_target;
  logic [2:0]  r_wrong_time;
  logic [7:0]  r_score;
  logic        r_hit;
  logic        r_wrong;
  logic        r_game_over;
  logic        r_busy;

  logic [3:0]  w_rise;
  logic [3:0]  w_target_mask;
  logic [2:0]  w_wrong_inc;

  // Only fresh presses count; a button held across a state change has btn_q set
  // and therefore never produces a second rise.
  assign w_rise        = bus.btn & ~r_btn_q;
  // A rise equal to the one-hot target mask is both one-hot and on target.
  assign w_target_mask = 4'b0001 << r_target;
  assign w_wrong_inc   = (r_wrong_time == LP_MAX_WRONG) ? r_wrong_time
                                                        : r_wrong_time + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_btn_q      <= 4'b0000;
      r_timer      <= 32'd0;
      r_target     <= 2'd0;
      r_wrong_time <= 3'd0;
      r_score      <= 8'd0;
      r_hit        <= 1'b0;
      r_wrong      <= 1'b0;
      r_game_over  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_btn_q <= bus.btn;
      r_hit   <= 1'b0;
      r_wrong <= 1'b0;

      if (bus.start) begin
        // start wins from every state: fresh game, waiting for a target
        r_wrong_time <= 3'd0;
        r_score      <= 8'd0;
        r_state      <= ST_ARMED;
        r_busy       <= 1'b1;
        r_game_over  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_busy      <= 1'b0;
            r_game_over <= 1'b0;
          end

          ST_ARMED: begin
            if (bus.target_valid) begin
              // a press landing with the target is absorbed into btn_q unjudged
              r_target <= bus.target_id;
              r_timer  <= LP_TIMER_LOAD;
              r_state  <= ST_WINDOW;
            end else if (|w_rise) begin
              r_wrong      <= 1'b1;
              r_wrong_time <= w_wrong_inc;
              r_state      <= ST_RELEASE;
            end
          end

          ST_WINDOW: begin
            // a press on the last window cycle is judged; timeout is suppressed
            if (|w_rise) begin
              if (w_rise == w_target_mask) begin
                r_hit <= 1'b1;
                if (r_score != 8'hFF) r_score <= r_score + 8'd1;
              end else begin
                r_wrong      <= 1'b1;
                r_wrong_time <= w_wrong_inc;
              end
              r_state <= ST_RELEASE;
            end else if (r_timer == 32'd0) begin
              r_wrong      <= 1'b1;
              r_wrong_time <= w_wrong_inc;
              r_state      <= ST_RELEASE;
            end else begin
              r_timer <= r_timer - 32'd1;
            end
          end

          ST_RELEASE: begin
            if (bus.btn == 4'b0000) begin
              if (r_wrong_time == LP_MAX_WRONG) begin
                r_state     <= ST_OVER;
                r_busy      <= 1'b0;
                r_game_over <= 1'b1;
              end else begin
                r_state <= ST_ARMED;
              end
            end
          end

          ST_OVER: begin
            r_busy      <= 1'b0;
            r_game_over <= 1'b1;
          end

          default: begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_game_over <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.wrong_time = r_wrong_time;
  assign bus.score      = r_score;
  assign bus.hit        = r_hit;
  assign bus.wrong      = r_wrong;
  assign bus.game_over  = r_game_over;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_reflex_judge.sv
// Self-checking bench for reflex_judge with a short window and three lives.
// Latency: checks pulses land one cycle after the judged cycle.
// Backpressure: n/a; the bench drives pulses and levels directly.
module tb_reflex_judge;

  localparam int WC = 8;
  localparam int MW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reflex_judge_if u_if ();

  reflex_judge #(.WINDOW_CYCLES(WC), .MAX_WRONG(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int hit_cnt  = 0;
  int wrong_cnt = 0;

  // reference model: game-level bookkeeping only
  int exp_score   = 0;
  int exp_wrong   = 0;
  bit exp_over    = 0;
  bit exp_started = 0;

  // pulse counters sampled mid-low-phase, away from the active edge
  always @(negedge clk) begin
    #1;
    if (u_if.hit === 1'b1)   hit_cnt++;
    if (u_if.wrong === 1'b1) wrong_cnt++;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_score"}, 32'(u_if.score), 32'(exp_score));
    check({tag, "_wrong_time"}, 32'(u_if.wrong_time), 32'(exp_wrong));
    check({tag, "_busy"}, 32'(u_if.busy), 32'(exp_started && !exp_over));
    check({tag, "_game_over"}, 32'(u_if.game_over), 32'(exp_over));
  endtask

  task automatic do_start();
    @(negedge clk);
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    exp_score = 0; exp_wrong = 0; exp_over = 0; exp_started = 1;
    check_status("start");
  endtask

  // kind: 0 correct, 1 wrong single, 2 multi-button, 3 timeout,
  //       4 early press in ARMED, 5 press held from target cycle (timeout)
  task automatic round(input int kind, input int d, input logic [1:0] t);
    int h0, w0;
    bit exp_hit;
    logic [3:0] pb;
    logic [1:0] o;
    h0 = hit_cnt; w0 = wrong_cnt;
    exp_hit = (kind == 0);
    pb = 4'b0000;
    if (kind == 4) begin
      @(negedge clk);
      u_if.btn = 4'($urandom_range(1, 15));
      @(negedge clk);
      check("early_hit", 32'(u_if.hit), 32'd0);
      check("early_wrong", 32'(u_if.wrong), 32'd1);
    end else begin
      @(negedge clk);
      u_if.target_valid = 1'b1;
      u_if.target_id    = t;
      if (kind == 5) u_if.btn = 4'($urandom_range(1, 15));
      @(negedge clk);
      u_if.target_valid = 1'b0;
      u_if.target_id    = 2'($urandom_range(0, 3));
      if (kind == 3 || kind == 5) begin
        tick(WC - 1);
        check("pre_timeout_wrong", 32'(u_if.wrong), 32'd0);
        @(negedge clk);
        check("timeout_wrong", 32'(u_if.wrong), 32'd1);
        check("timeout_hit", 32'(u_if.hit), 32'd0);
      end else begin
        for (int i = 0; i < d; i++) begin
          // a second target inside the window must not move the latched one
          if (i == 0) begin
            u_if.target_valid = 1'b1;
            u_if.target_id    = ~t;
          end
          @(negedge clk);
          u_if.target_valid = 1'b0;
        end
        if (kind == 0) begin
          pb = 4'b0001 << t;
        end else if (kind == 1) begin
          o  = t + 2'($urandom_range(1, 3));
          pb = 4'b0001 << o;
        end else begin
          do pb = 4'($urandom_range(1, 15)); while ($countones(pb) < 2);
        end
        u_if.btn = pb;
        @(negedge clk);
        check("press_hit", 32'(u_if.hit), 32'(exp_hit));
        check("press_wrong", 32'(u_if.wrong), 32'(!exp_hit));
      end
    end
    if (exp_hit) exp_score = (exp_score < 255) ? exp_score + 1 : 255;
    else begin
      exp_wrong = exp_wrong + 1;
    end
    if (u_if.btn != 4'b0000) begin
      tick($urandom_range(0, 2));
      check("release_busy", 32'(u_if.busy), 32'd1);
      u_if.btn = 4'b0000;
    end
    tick(2);
    if (exp_wrong == MW) exp_over = 1;
    check("round_hits", 32'(hit_cnt - h0), 32'(exp_hit));
    check("round_wrongs", 32'(wrong_cnt - w0), 32'(!exp_hit));
    check_status("round");
  endtask

  // in OVER nothing but start may change anything
  task automatic over_poke();
    int h0, w0;
    h0 = hit_cnt; w0 = wrong_cnt;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      u_if.target_valid = 1'($urandom_range(0, 1));
      u_if.target_id    = 2'($urandom_range(0, 3));
      u_if.btn          = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    u_if.target_valid = 1'b0;
    u_if.btn          = 4'b0000;
    tick(WC + 2);
    check("over_hits", 32'(hit_cnt - h0), 32'd0);
    check("over_wrongs", 32'(wrong_cnt - w0), 32'd0);
    check_status("over");
  endtask

  initial begin
    int h0, w0;
    logic [1:0] t;
    u_if.start = 1'b0; u_if.target_valid = 1'b0; u_if.target_id = 2'd0; u_if.btn = 4'b0000;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    check("rst_hit", 32'(u_if.hit), 32'd0);
    check("rst_wrong", 32'(u_if.wrong), 32'd0);
    check_status("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE ignores targets and presses until start
    h0 = hit_cnt; w0 = wrong_cnt;
    @(negedge clk); u_if.target_valid = 1'b1; u_if.btn = 4'b0001;
    @(negedge clk); u_if.target_valid = 1'b0; u_if.btn = 4'b0010;
    tick(WC + 2);
    u_if.btn = 4'b0000;
    tick(2);
    check("idle_pulses", 32'(hit_cnt - h0 + wrong_cnt - w0), 32'd0);
    check_status("idle");

    // directed game: hit, timeout, last-cycle hit, wrong press, early, held press
    do_start();
    round(0, 2, 2'd2);
    round(3, 0, 2'd0);
    round(0, WC - 1, 2'd0);
    round(1, 1, 2'd1);
    round(2, 4, 2'd3);
    over_poke();
    do_start();
    round(4, 0, 2'd0);
    round(5, 0, 2'd1);
    round(0, 0, 2'd3);
    round(3, 0, 2'd2);
    over_poke();
    do_start();

    // score saturation
    for (int i = 0; i < 258; i++) round(0, $urandom_range(0, 1), 2'($urandom_range(0, 3)));
    check("sat_score", 32'(u_if.score), 32'd255);

    // randomized play
    do_start();
    for (int i = 0; i < 80; i++) begin
      round($urandom_range(0, 5), $urandom_range(0, WC - 1), 2'($urandom_range(0, 3)));
      if (exp_over) begin
        over_poke();
        do_start();
      end else if ($urandom_range(0, 9) == 0) begin
        do_start();
      end
    end

    // reset while a correct press is pending in the window
    do_start();
    round(0, 1, 2'd1);
    round(0, 3, 2'd2);
    t = 2'($urandom_range(0, 3));
    @(negedge clk); u_if.target_valid = 1'b1; u_if.target_id = t;
    @(negedge clk); u_if.target_valid = 1'b0;
    @(negedge clk); u_if.btn = 4'b0001 << t;
    h0 = hit_cnt; w0 = wrong_cnt;
    #2 rst_n = 1'b0;
    #1;
    exp_score = 0; exp_wrong = 0; exp_over = 0; exp_started = 0;
    check("midrst_hit", 32'(u_if.hit), 32'd0);
    check("midrst_wrong", 32'(u_if.wrong), 32'd0);
    check_status("midrst");
    tick(2);
    rst_n = 1'b1;
    tick(3);
    u_if.target_valid = 1'b1;
    @(negedge clk); u_if.target_valid = 1'b0;
    tick(WC + 2);
    u_if.btn = 4'b0000;
    tick(2);
    check("postrst_pulses", 32'(hit_cnt - h0 + wrong_cnt - w0), 32'd0);
    check_status("postrst");
    do_start();
    round(0, 2, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reflex_judge.md
REFLEX_JUDGE -- requirements
Module: reflex_judge

Interface
REQ-001 Parameter WINDOW_CYCLES, default 50_000_000, response window length in clk cycles (legal range 2..2^32-1).
REQ-002 Parameter MAX_WRONG, default 3, wrong-count value that ends the game (legal range 1..7).
REQ-003 Clocking SHALL be fixed: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle pulse; begins a new game from IDLE or OVER.
REQ-007 target_valid  input  1  single-cycle pulse; a new target is shown.
REQ-008 target_id  input  2  index of the button that must be pressed; sampled only with target_valid.
REQ-009 btn  input  4  synchronized, debounced button levels; 1 = pressed.
REQ-010 wrong_time  output  3  accumulated wrong/miss count; feeds the fail-LED stage.
REQ-011 score  output  8  correct-hit count.
REQ-012 hit  output  1  one-cycle pulse on a correct press.
REQ-013 wrong  output  1  one-cycle pulse on any wrong press or timeout.
REQ-014 game_over  output  1  level; high only in OVER.
REQ-015 busy  output  1  level; high in ARMED, WINDOW, RELEASE.

Function
REQ-016 btn_q SHALL register btn each cycle; rise = btn & ~btn_q; only rise is judged.
REQ-017 FSM states SHALL be IDLE, ARMED, WINDOW, RELEASE, OVER.
REQ-018 IDLE: on start, clear wrong_time and score, go ARMED next cycle; all other inputs ignored.
REQ-019 ARMED: on target_valid, latch target_id, load timer = WINDOW_CYCLES-1, go WINDOW.
REQ-020 ARMED: any nonzero rise without target_valid (early press) SHALL count as wrong, go RELEASE.
REQ-021 ARMED: target_valid and nonzero rise in same cycle SHALL be treated as target load only; the press is not judged.
REQ-022 WINDOW: timer decrements by 1 per cycle while no rise.
REQ-023 WINDOW: rise one-hot and equal to latched target -> hit pulse, score+1 saturating at 255, go RELEASE.
REQ-024 WINDOW: rise not matching target, or more than one bit set -> wrong, go RELEASE.
REQ-025 WINDOW: timer == 0 with no rise -> wrong (miss), go RELEASE.
REQ-026 WINDOW: rise in the same cycle the timer is 0 SHALL be judged as a press; timeout does not also fire.
REQ-027 WINDOW: target_valid ignored; latched target unchanged.
REQ-028 Each wrong event SHALL increment wrong_time by exactly 1; wrong_time never exceeds MAX_WRONG.
REQ-029 hit and wrong SHALL assert in the cycle after the judged rise/timeout cycle (registered), never both together.
REQ-030 RELEASE: wait until btn == 4'b0000; then go OVER if wrong_time == MAX_WRONG, else ARMED.
REQ-031 RELEASE: target_valid and rise ignored; no events generated.
REQ-032 OVER: wrong_time and score held; all inputs except start ignored; start -> clear counters, go ARMED.
REQ-033 start in ARMED, WINDOW or RELEASE SHALL restart: clear counters, go ARMED.
REQ-034 Buttons held across a state change SHALL not produce a new rise.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, wrong_time=0, score=0, hit=0, wrong=0, game_over=0, busy=0, btn_q=0, timer=0, latched target=0.
REQ-036 Reset asserted mid-WINDOW SHALL discard the pending judgement; no hit/wrong pulse after release.
REQ-037 After rst_n deasserts, the block SHALL stay in IDLE until start.

Verification (WINDOW_CYCLES=8, MAX_WRONG=3)
REQ-038 start; target_valid id=2; btn=4'b0100 after 3 cycles, release -> hit one pulse, score=1, wrong_time=0, back to ARMED.
REQ-039 start; target id=1; btn=4'b0001 -> wrong pulse, wrong_time=1; btn=4'b0011 in next window -> wrong_time=2.
REQ-040 start; target id=0; no press -> wrong pulse exactly 8 cycles after load, wrong_time=1; press on cycle 8 instead -> hit, no timeout.
REQ-041 Three wrong events, buttons released -> game_over=1, busy=0, wrong_time=3; further presses/targets leave outputs unchanged; start -> wrong_time=0, ARMED.
REQ-042 Early press in ARMED -> wrong_time+1; button held through next target_valid and window -> no hit, timeout wrong.
REQ-043 rst_n low mid-WINDOW with pending correct press -> all outputs 0 asynchronously, no pulse after reset release, state IDLE.
